// File: rtl/cust1_job_engine.sv
// cust1_job_engine: command-driven job slot engine.
// Commands are accepted only while the control FSM is idle. Most ops answer on
// the cycle after acceptance; WAIT and FENCE may park the FSM until the
// relevant job(s) leave RUNNING, then answer one cycle later.
module cust1_job_engine #(
  parameter int XLEN       = 32,
  parameter int NUM_SLOTS  = 4,
  parameter int NUM_CFG    = 4,
  parameter int JOB_LAT    = 8,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [XLEN-1:0]       cmd_rs1,
  input  logic [XLEN-1:0]       cmd_rs2,
  input  logic [HART_ID_W-1:0]  cmd_hart_id,
  input  logic [REG_ADDR_W-1:0] cmd_rd,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_data,
  output logic [HART_ID_W-1:0]  rsp_hart_id,
  output logic [REG_ADDR_W-1:0] rsp_rd,
  output logic                  busy
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CFG_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int CNT_W  = $clog2(JOB_LAT + 1);

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_POLL   = 3'd1;
  localparam logic [2:0] OP_WAIT   = 3'd2;
  localparam logic [2:0] OP_GETERR = 3'd3;
  localparam logic [2:0] OP_SETCFG = 3'd4;
  localparam logic [2:0] OP_GETCFG = 3'd5;
  localparam logic [2:0] OP_FENCE  = 3'd6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  typedef enum logic [1:0] {FSM_IDLE, FSM_WAIT_JOB, FSM_WAIT_ALL} fsm_t;

  fsm_t                  state_reg, state_next;
  logic [1:0]            status_reg [NUM_SLOTS];
  logic [CNT_W-1:0]      cnt_reg    [NUM_SLOTS];
  logic                  err_reg    [NUM_SLOTS];
  logic [XLEN-1:0]       cfg_reg    [NUM_CFG];
  logic [SLOT_W-1:0]     wait_idx_reg;
  logic [HART_ID_W-1:0]  tag_hart_reg;
  logic [REG_ADDR_W-1:0] tag_rd_reg;

  logic                  accept;
  logic                  slot_id_ok;
  logic [SLOT_W-1:0]     slot_sel;
  logic [1:0]            sel_status;
  logic [1:0]            wait_status;
  logic                  cfg_ok;
  logic [CFG_W-1:0]      cfg_sel;
  logic [NUM_SLOTS-1:0]  running_vec;
  logic                  any_running;
  logic                  alloc_found;
  logic [SLOT_W-1:0]     alloc_idx;
  logic                  start_go;
  logic                  cfg_we;
  logic                  rsp_load;
  logic [XLEN-1:0]       rsp_data_next;

  assign accept      = cmd_valid && cmd_ready;
  assign cmd_ready   = (state_reg == FSM_IDLE);
  assign slot_id_ok  = (cmd_rs1 != '0) && (cmd_rs1 <= XLEN'(NUM_SLOTS));
  assign slot_sel    = SLOT_W'(cmd_rs1 - XLEN'(1));
  assign sel_status  = status_reg[slot_sel];
  assign wait_status = status_reg[wait_idx_reg];
  assign cfg_ok      = (cmd_rs1 < XLEN'(NUM_CFG));
  assign cfg_sel     = CFG_W'(cmd_rs1);
  assign any_running = |running_vec;
  assign start_go    = accept && (cmd_op == OP_START) && alloc_found;
  assign cfg_we      = accept && (cmd_op == OP_SETCFG) && cfg_ok;
  assign busy        = any_running || (state_reg != FSM_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_running
      assign running_vec[gi] = (status_reg[gi] == ST_RUNNING);
    end
  endgenerate

  // Lowest-index slot that is not RUNNING (IDLE, DONE and ERROR are reusable).
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!running_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = SLOT_W'(i);
      end
    end
  end

  // Per-slot job state: launch on START, count down while RUNNING, then DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        status_reg[i] <= ST_IDLE;
        cnt_reg[i]    <= '0;
        err_reg[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (start_go && (alloc_idx == SLOT_W'(i))) begin
          if (cmd_rs1 == '0) begin
            status_reg[i] <= ST_ERROR;
            cnt_reg[i]    <= '0;
            err_reg[i]    <= 1'b1;
          end else begin
            status_reg[i] <= ST_RUNNING;
            cnt_reg[i]    <= CNT_W'(JOB_LAT);
            err_reg[i]    <= 1'b0;
          end
        end else if (running_vec[i]) begin
          if (cnt_reg[i] <= CNT_W'(1)) begin
            status_reg[i] <= ST_DONE;
            cnt_reg[i]    <= '0;
            err_reg[i]    <= 1'b0;
          end else begin
            cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Config register file; a write is visible to a GETCFG on the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_reg[i] <= '0;
    end else if (cfg_we) begin
      cfg_reg[cfg_sel] <= cmd_rs2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= FSM_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state: park on WAIT of a running job or FENCE with jobs in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FSM_IDLE: begin
        if (accept && (cmd_op == OP_WAIT) && slot_id_ok && (sel_status == ST_RUNNING))
          state_next = FSM_WAIT_JOB;
        else if (accept && (cmd_op == OP_FENCE) && any_running)
          state_next = FSM_WAIT_ALL;
      end
      FSM_WAIT_JOB: if (wait_status != ST_RUNNING) state_next = FSM_IDLE;
      FSM_WAIT_ALL: if (!any_running) state_next = FSM_IDLE;
      default:      state_next = FSM_IDLE;
    endcase
  end

  // FSM outputs: decide whether a response fires this edge and its payload.
  always_comb begin
    rsp_load      = 1'b0;
    rsp_data_next = '0;
    case (state_reg)
      FSM_IDLE: begin
        if (accept) begin
          rsp_load = 1'b1;
          case (cmd_op)
            OP_START:  rsp_data_next = alloc_found ? (XLEN'(alloc_idx) + XLEN'(1)) : '0;
            OP_POLL:   rsp_data_next = slot_id_ok ? XLEN'(sel_status) : '0;
            OP_WAIT: begin
              if (slot_id_ok && (sel_status == ST_RUNNING)) rsp_load = 1'b0;
              rsp_data_next = slot_id_ok ? XLEN'(sel_status) : '0;
            end
            OP_GETERR: rsp_data_next = slot_id_ok ? XLEN'(err_reg[slot_sel]) : XLEN'(2);
            OP_SETCFG: rsp_data_next = cfg_ok ? '0 : XLEN'(1);
            OP_GETCFG: rsp_data_next = cfg_ok ? cfg_reg[cfg_sel] : '0;
            OP_FENCE:  rsp_load = !any_running;
            default:   rsp_data_next = '1;
          endcase
        end
      end
      FSM_WAIT_JOB: begin
        rsp_load      = (wait_status != ST_RUNNING);
        rsp_data_next = XLEN'(wait_status);
      end
      FSM_WAIT_ALL: rsp_load = !any_running;
      default: ;
    endcase
  end

  // Capture tags and wait target at acceptance for deferred responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_idx_reg <= '0;
      tag_hart_reg <= '0;
      tag_rd_reg   <= '0;
    end else if (accept) begin
      wait_idx_reg <= slot_sel;
      tag_hart_reg <= cmd_hart_id;
      tag_rd_reg   <= cmd_rd;
    end
  end

  // Response register: one-cycle valid pulse, payload and tags held between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_hart_id <= '0;
      rsp_rd      <= '0;
    end else begin
      rsp_valid <= rsp_load;
      if (rsp_load) begin
        rsp_data    <= rsp_data_next;
        rsp_hart_id <= (state_reg == FSM_IDLE) ? cmd_hart_id : tag_hart_reg;
        rsp_rd      <= (state_reg == FSM_IDLE) ? cmd_rd : tag_rd_reg;
      end
    end
  end

endmodule
